// File: rtl/ir_pkg.sv
// Shared types and defaults for the IR line-sensor scan controller.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TMR,
    SETTLE,
    START_CNV,
    WAIT_CNV,
    DONE
  } state_t;

  localparam logic [11:0] LINE_ON_DEF  = 12'h040;
  localparam logic [11:0] LINE_OFF_DEF = 12'h030;

endpackage

// File: rtl/ir_peak_trk.sv
// Running maximum with channel index; strict compare keeps the
// lowest channel on ties because channels arrive in ascending order.
module ir_peak_trk #(
  parameter int RES_W = 12,
  parameter int CH_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             upd,
  input  logic [CH_W-1:0]  ch,
  input  logic [RES_W-1:0] val,
  output logic [RES_W-1:0] peak,
  output logic [CH_W-1:0]  peak_ch
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      peak    <= '0;
      peak_ch <= '0;
    end else if (upd && (val > peak)) begin
      peak    <= val;
      peak_ch <= ch;
    end
  end

endmodule

// File: rtl/ir_scan_ctrl.sv
// IR line-sensor scan controller: emitter settle, sequential A2D
// conversions with timeout, peak tracking and hysteretic line flag.
module ir_scan_ctrl
  import ir_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int RES_W       = 12,
  parameter int ROUND_BITS  = 18,
  parameter int SETTLE_BITS = 12,
  parameter int TMO_BITS    = 10,
  parameter logic [RES_W-1:0] LINE_ON =
    RES_W'(LINE_ON_DEF),
  parameter logic [RES_W-1:0] LINE_OFF =
    RES_W'(LINE_OFF_DEF),
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic                    trig,
  output logic                    cnv_req,
  output logic [CH_W-1:0]         cnv_chnnl,
  input  logic                    cnv_done,
  input  logic [RES_W-1:0]        cnv_res,
  output logic                    IR_en,
  output logic [NUM_CH*RES_W-1:0] ir_vals,
  output logic                    IR_vld,
  output logic [RES_W-1:0]        IR_max,
  output logic [CH_W-1:0]         max_ch,
  output logic                    line_present,
  output logic                    tmo_err,
  output logic                    busy
);

  localparam int TMR_W =
    (ROUND_BITS > SETTLE_BITS) ? ROUND_BITS : SETTLE_BITS;

  state_t state, nxt;

  logic [TMR_W-1:0]        tmr;
  logic [TMO_BITS-1:0]     tmo;
  logic [NUM_CH*RES_W-1:0] stage;
  logic                    rnd_err;
  logic                    tmr_end;
  logic                    set_end;
  logic                    tmo_end;
  logic                    last;
  logic                    conv_end;
  logic [RES_W-1:0]        slot_val;
  logic [RES_W-1:0]        peak;
  logic [CH_W-1:0]         peak_ch;

  assign tmr_end  = &tmr[ROUND_BITS-1:0];
  assign set_end  = &tmr[SETTLE_BITS-1:0];
  assign tmo_end  = &tmo;
  assign last     = cnv_chnnl == CH_W'(NUM_CH - 1);
  assign slot_val = cnv_done ? cnv_res : '0;
  assign busy     = state != IDLE;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt      = state;
    cnv_req  = 1'b0;
    IR_en    = 1'b0;
    conv_end = 1'b0;
    unique case (state)
      IDLE: begin
        if (!mode)     nxt = WAIT_TMR;
        else if (trig) nxt = SETTLE;
      end
      WAIT_TMR: begin
        if (tmr_end) nxt = SETTLE;
      end
      SETTLE: begin
        IR_en = 1'b1;
        if (set_end) nxt = START_CNV;
      end
      START_CNV: begin
        IR_en   = 1'b1;
        cnv_req = 1'b1;
        nxt     = WAIT_CNV;
      end
      WAIT_CNV: begin
        IR_en    = 1'b1;
        conv_end = cnv_done | tmo_end;
        if (conv_end) nxt = last ? DONE : START_CNV;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  ir_peak_trk #(
    .RES_W(RES_W),
    .CH_W (CH_W)
  ) u_peak (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == IDLE),
    .upd    (conv_end),
    .ch     (cnv_chnnl),
    .val    (slot_val),
    .peak   (peak),
    .peak_ch(peak_ch)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr          <= '0;
      tmo          <= '0;
      cnv_chnnl    <= '0;
      stage        <= '0;
      rnd_err      <= 1'b0;
      ir_vals      <= '0;
      IR_max       <= '0;
      max_ch       <= '0;
      line_present <= 1'b0;
      tmo_err      <= 1'b0;
      IR_vld       <= 1'b0;
    end else begin
      // vld follows DONE so it coincides with the updated outputs
      IR_vld <= state == DONE;
      if (state == IDLE || (state == WAIT_TMR && tmr_end))
        tmr <= '0;
      else if (state == WAIT_TMR || state == SETTLE)
        tmr <= tmr + TMR_W'(1);
      if (state == START_CNV)
        tmo <= '0;
      else if (state == WAIT_CNV)
        tmo <= tmo + TMO_BITS'(1);
      if (state == SETTLE && set_end)
        cnv_chnnl <= '0;
      else if (conv_end && !last)
        cnv_chnnl <= cnv_chnnl + CH_W'(1);
      if (conv_end)
        stage[cnv_chnnl*RES_W +: RES_W] <= slot_val;
      if (state == IDLE)
        rnd_err <= 1'b0;
      else if (conv_end && !cnv_done)
        rnd_err <= 1'b1;
      if (state == DONE) begin
        ir_vals <= stage;
        IR_max  <= peak;
        max_ch  <= peak_ch;
        tmo_err <= rnd_err;
        if (peak > LINE_ON)       line_present <= 1'b1;
        else if (peak < LINE_OFF) line_present <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ir_scan_ctrl.sv
// Scoreboard bench: one single-shot DUT with directed rounds and
// one fast continuous-mode DUT checked for sequence and period.
module tb_ir_scan_ctrl;

  localparam int N  = 8;
  localparam int RW = 12;
  localparam int D  = 20;
  // trig cycle to IR_vld cycle, ideal A2D answering D cycles late
  localparam int LAT = (1 << 12) + N * (D + 1) + 2;
  localparam int FN = 5;
  localparam int FD = 3;
  // IDLE + round wait + settle + conversions + DONE
  localparam int F_PER =
    1 + (1 << 10) + (1 << 4) + FN * (FD + 1) + 1;

  localparam logic [N*RW-1:0] V_RAMP =
    96'h080_070_060_050_040_030_020_010;
  localparam logic [N*RW-1:0] V_TMO =
    96'h080_070_060_050_000_030_020_010;
  localparam logic [N*RW-1:0] V_P50 =
    96'h000_000_000_000_050_000_000_000;
  localparam logic [N*RW-1:0] V_P35 =
    96'h000_000_000_000_035_000_000_000;
  localparam logic [N*RW-1:0] V_P20 =
    96'h000_000_000_000_020_000_000_000;
  localparam logic [N*RW-1:0] V_TIE =
    96'h000_000_FFF_000_000_FFF_000_000;

  localparam int K_IDLE  = 0;
  localparam int K_ROUND = 1;
  localparam int K_FAST  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            rst = 1'b1;
  logic            mode = 1'b1;
  logic            trig = 1'b0;
  logic            cnv_done = 1'b0;
  logic [RW-1:0]   cnv_res = '0;
  logic            cnv_req;
  logic [2:0]      cnv_chnnl;
  logic            IR_en;
  logic [N*RW-1:0] ir_vals;
  logic            IR_vld;
  logic [RW-1:0]   IR_max;
  logic [2:0]      max_ch;
  logic            line_present;
  logic            tmo_err;
  logic            busy;

  logic             f_rst = 1'b1;
  logic             f_mode = 1'b1;
  logic             f_trig = 1'b0;
  logic             f_cnv_done = 1'b0;
  logic [RW-1:0]    f_cnv_res = '0;
  logic             f_cnv_req;
  logic [2:0]       f_cnv_chnnl;
  logic             f_IR_en;
  logic [FN*RW-1:0] f_ir_vals;
  logic             f_IR_vld;
  logic [RW-1:0]    f_IR_max;
  logic [2:0]       f_max_ch;
  logic             f_line;
  logic             f_tmo;
  logic             f_busy;

  ir_scan_ctrl #(
    .NUM_CH(N)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .trig        (trig),
    .cnv_req     (cnv_req),
    .cnv_chnnl   (cnv_chnnl),
    .cnv_done    (cnv_done),
    .cnv_res     (cnv_res),
    .IR_en       (IR_en),
    .ir_vals     (ir_vals),
    .IR_vld      (IR_vld),
    .IR_max      (IR_max),
    .max_ch      (max_ch),
    .line_present(line_present),
    .tmo_err     (tmo_err),
    .busy        (busy)
  );

  ir_scan_ctrl #(
    .NUM_CH     (FN),
    .ROUND_BITS (10),
    .SETTLE_BITS(4),
    .TMO_BITS   (6)
  ) u_fast (
    .clk         (clk),
    .rst         (f_rst),
    .mode        (f_mode),
    .trig        (f_trig),
    .cnv_req     (f_cnv_req),
    .cnv_chnnl   (f_cnv_chnnl),
    .cnv_done    (f_cnv_done),
    .cnv_res     (f_cnv_res),
    .IR_en       (f_IR_en),
    .ir_vals     (f_ir_vals),
    .IR_vld      (f_IR_vld),
    .IR_max      (f_IR_max),
    .max_ch      (f_max_ch),
    .line_present(f_line),
    .tmo_err     (f_tmo),
    .busy        (f_busy)
  );

  logic [RW-1:0] tbl [N];
  int skip_ch = -1;
  bit m_pend = 1'b0;
  int m_left = 0;
  int m_ch = 0;

  // A2D model: answers D cycles after cnv_req unless muted
  always begin
    @(posedge clk); #1;
    cnv_done = 1'b0;
    if (m_pend) begin
      m_left--;
      if (m_left == 0) begin
        m_pend = 1'b0;
        if (m_ch != skip_ch) begin
          cnv_done = 1'b1;
          cnv_res  = tbl[m_ch];
        end
      end
    end
    if (cnv_req) begin
      m_pend = 1'b1;
      m_left = D;
      m_ch   = int'(cnv_chnnl);
    end
  end

  bit f_pend = 1'b0;
  int f_left = 0;
  int f_ch = 0;

  always begin
    @(posedge clk); #1;
    f_cnv_done = 1'b0;
    if (f_pend) begin
      f_left--;
      if (f_left == 0) begin
        f_pend     = 1'b0;
        f_cnv_done = 1'b1;
        f_cnv_res  = 12'h100 + RW'(f_ch);
      end
    end
    if (f_cnv_req) begin
      f_pend = 1'b1;
      f_left = FD;
      f_ch   = int'(f_cnv_chnnl);
    end
  end

  typedef struct {
    int              kind;
    logic [N*RW-1:0] vals;
    logic [RW-1:0]   mx;
    logic [2:0]      mch;
    logic            ln;
    logic            tm;
    int              t0;
    int              lat;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  int wd = 0;
  int f_req = 0;
  int f_last = -1;
  int f_rounds = 0;

  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].kind == K_IDLE) begin
      chk("idle_ir_vals", ir_vals, '0);
      chk("idle_outputs",
          {IR_max, max_ch, line_present, tmo_err, IR_vld,
           IR_en, cnv_req, cnv_chnnl, busy}, '0);
      void'(sb.pop_front());
    end else if (sb.size() != 0 && sb[0].kind == K_FAST) begin
      chk("fast_rounds_seen", 128'(f_rounds > 20), 1);
      void'(sb.pop_front());
    end else if (sb.size() != 0) begin
      if (IR_vld) begin
        chk("ir_vals", ir_vals, sb[0].vals);
        chk("IR_max", IR_max, sb[0].mx);
        chk("max_ch", max_ch, sb[0].mch);
        chk("line_present", line_present, sb[0].ln);
        chk("tmo_err", tmo_err, sb[0].tm);
        if (sb[0].lat != 0)
          chk("latency", cyc - sb[0].t0, sb[0].lat);
        void'(sb.pop_front());
        wd = 0;
      end else begin
        wd++;
        if (wd > 14000) begin
          n_chk++;
          n_fail++;
          $display("FAIL round_timeout: no IR_vld in %0d cycles",
                   wd);
          void'(sb.pop_front());
          wd = 0;
        end
      end
    end else if (IR_vld) begin
      chk("stray_IR_vld", IR_vld, 1'b0);
    end
    if (f_cnv_req) begin
      chk("fast_chnnl", f_cnv_chnnl, f_req);
      f_req++;
    end
    if (f_IR_vld) begin
      chk("fast_req_count", f_req, FN);
      if (f_last >= 0)
        chk("fast_period", cyc - f_last, F_PER);
      f_last = cyc;
      f_req  = 0;
      f_rounds++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_kind(input int k);
    exp_t e;
    e = '{default: '0};
    e.kind = k;
    sb.push_back(e);
  endtask

  task automatic set_ramp();
    for (int k = 0; k < N; k++) tbl[k] = RW'(16 * (k + 1));
  endtask

  task automatic set_one(input int k, input logic [RW-1:0] v);
    for (int i = 0; i < N; i++) tbl[i] = '0;
    tbl[k] = v;
  endtask

  task automatic round(input logic [N*RW-1:0] v,
                       input logic [RW-1:0] mx,
                       input logic [2:0] mc,
                       input logic ln,
                       input logic tm,
                       input int lat);
    exp_t e;
    e.kind = K_ROUND;
    e.vals = v;
    e.mx   = mx;
    e.mch  = mc;
    e.ln   = ln;
    e.tm   = tm;
    e.t0   = cyc;
    e.lat  = lat;
    sb.push_back(e);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int i = 0; i < 15000 && sb.size() != 0; i++) tick();
    tick(3);
  endtask

  initial begin
    tick(3);
    rst    = 1'b0;
    f_rst  = 1'b0;
    f_mode = 1'b0;
    push_kind(K_IDLE);
    tick(2);

    set_ramp();
    round(V_RAMP, 12'h080, 3'd7, 1'b1, 1'b0, LAT);

    set_one(3, 12'h050);
    round(V_P50, 12'h050, 3'd3, 1'b1, 1'b0, LAT);
    set_one(3, 12'h035);
    round(V_P35, 12'h035, 3'd3, 1'b1, 1'b0, LAT);
    set_one(3, 12'h020);
    round(V_P20, 12'h020, 3'd3, 1'b0, 1'b0, LAT);

    set_one(2, 12'hFFF);
    tbl[5] = 12'hFFF;
    round(V_TIE, 12'hFFF, 3'd2, 1'b1, 1'b0, LAT);

    set_ramp();
    skip_ch = 3;
    round(V_TMO, 12'h080, 3'd7, 1'b1, 1'b1, 0);
    skip_ch = -1;
    round(V_RAMP, 12'h080, 3'd7, 1'b1, 1'b0, LAT);

    // reset while channel 4 is in flight; its late answer is stray
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int i = 0;
         i < 6000 && !(cnv_req && cnv_chnnl == 3'd4);
         i++) tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_kind(K_IDLE);
    tick(40);
    push_kind(K_IDLE);
    tick(2);

    push_kind(K_FAST);
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
